// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control stage:
//   - state_e     : FSM state encoding (IDLE=00, RUN=01, PAUSE=10, 11 illegal)
//   - DEFAULT_*   : board defaults for the tick divider and key debounce time
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      BAD   = 2'b11
   } state_e;

   // 100 Hz count-enable from a 50 MHz board clock
   localparam int DEFAULT_TICK_DIV   = 500000;
   // 20 ms of stable key level at 50 MHz
   localparam int DEFAULT_DEB_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises one raw push-button, debounces it and emits a one-cycle press
// pulse on every accepted rising edge of the debounced level.
// Ports:
//   Clk   in  : system clock, rising edge
//   R     in  : synchronous active-high reset
//   Key   in  : raw asynchronous key, active-high when pressed
//   Level out : debounced key level
//   Press out : registered one-cycle pulse per accepted press (releases ignored)
// -----------------------------------------------------------------------------
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
   input  logic Clk,
   input  logic R,
   input  logic Key,
   output logic Level,
   output logic Press
);

   localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            db_q, db_d;
   logic            db_dly_q, db_dly_d;
   logic            press_q, press_d;
   logic [DC_W-1:0] dc_q, dc_d;

   always_comb begin
      sync1_d  = Key;
      sync2_d  = sync1_q;
      db_d     = db_q;
      dc_d     = '0;
      // A differing sample must persist DEB_CYCLES consecutive cycles; any
      // return to the current level restarts the count.
      if (sync2_q != db_q) begin
         if (dc_q == DC_LAST) begin
            db_d = sync2_q;
         end else begin
            dc_d = dc_q + DC_W'(1);
         end
      end
      // Edge detect against a delayed copy so the press lands one cycle
      // after the level change.
      db_dly_d = db_q;
      press_d  = db_q & ~db_dly_q;
   end

   always_ff @(posedge Clk) begin
      if (R) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         press_q  <= 1'b0;
         dc_q     <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         db_dly_q <= db_dly_d;
         press_q  <= press_d;
         dc_q     <= dc_d;
      end
   end

   assign Level = db_q;
   assign Press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Start/Stop and Clear control for a decade-counter stopwatch. Debounces both
// keys, runs the IDLE/RUN/PAUSE machine and divides the clock into a
// count-enable tick that is only issued while running.
// Ports:
//   Clk      in  : system clock, rising edge
//   R        in  : synchronous active-high reset
//   KeyStart in  : raw Start/Stop key
//   KeyClr   in  : raw Clear key
//   En       out : one-cycle count enable to the least-significant counter
//   CntR     out : one-cycle clear to all counters
//   Running  out : high while State = RUN
//   State    out : current state (IDLE=00, RUN=01, PAUSE=10)
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = DEFAULT_TICK_DIV,
   parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
   input  logic       Clk,
   input  logic       R,
   input  logic       KeyStart,
   input  logic       KeyClr,
   output logic       En,
   output logic       CntR,
   output logic       Running,
   output logic [1:0] State
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   // Index 0 = Start/Stop, index 1 = Clear
   logic [1:0] key_raw;
   logic [1:0] key_level;
   logic [1:0] key_press;

   assign key_raw = {KeyClr, KeyStart};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_key (
            .Clk   (Clk),
            .R     (R),
            .Key   (key_raw[gi]),
            .Level (key_level[gi]),
            .Press (key_press[gi])
         );
      end
   endgenerate

   // A press is honoured only while its debounced level is still asserted.
   logic start_press;
   logic clr_press;
   assign start_press = key_press[0] & key_level[0];
   assign clr_press   = key_press[1] & key_level[1];

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q, en_d;
   logic             cntr_q, cntr_d;
   logic             running_q, running_d;

   always_comb begin
      state_d = state_q;
      cntr_d  = 1'b0;
      if (state_q == BAD) begin
         state_d = IDLE;
      end else if (clr_press) begin
         // Clear has priority; a coincident start press is dropped.
         state_d = IDLE;
         cntr_d  = 1'b1;
      end else if (start_press) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      div_d = '0;
      case (state_q)
         RUN: begin
            if (state_d == RUN) begin
               div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
            end else if (state_d == PAUSE) begin
               // Freeze on the pausing edge so the partial tick survives.
               div_d = div_q;
            end
         end
         PAUSE: begin
            if (state_d == PAUSE) begin
               div_d = div_q;
            end else if (state_d == RUN) begin
               // A tick already issued on the pausing edge is not repeated.
               div_d = (div_q == DIV_MAX) ? '0 : div_q;
            end
         end
         default: div_d = '0;
      endcase
      en_d      = (state_q == RUN) && (div_q == DIV_MAX);
      running_d = (state_d == RUN);
   end

   always_ff @(posedge Clk) begin
      if (R) begin
         state_q   <= IDLE;
         div_q     <= '0;
         en_q      <= 1'b0;
         cntr_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         en_q      <= en_d;
         cntr_q    <= cntr_d;
         running_q <= running_d;
      end
   end

   assign En      = en_q;
   assign CntR    = cntr_q;
   assign Running = running_q;
   assign State   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3. Each step
// advances one rising edge; outputs are sampled 1 ns after that edge and
// compared as the vector {State, En, CntR, Running}.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;

   logic       Clk = 1'b0;
   logic       R = 1'b1;
   logic       KeyStart = 1'b0;
   logic       KeyClr = 1'b0;
   logic       En;
   logic       CntR;
   logic       Running;
   logic [1:0] State;

   int n_checks = 0;
   int n_fail = 0;

   stopwatch_ctrl #(
      .TICK_DIV   (4),
      .DEB_CYCLES (3)
   ) dut (
      .Clk      (Clk),
      .R        (R),
      .KeyStart (KeyStart),
      .KeyClr   (KeyClr),
      .En       (En),
      .CntR     (CntR),
      .Running  (Running),
      .State    (State)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      R = 1'b1;
      step();
      step();
      got = {State, En, CntR, Running};
      n_checks++;
      if (got !== {S_IDLE, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_held got=%b exp=%b", got, {S_IDLE, 3'b000});
      end
      R = 1'b0;
      step();
      got = {State, En, CntR, Running};
      n_checks++;
      if (got !== {S_IDLE, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_release got=%b exp=%b", got, {S_IDLE, 3'b000});
      end
      $display("test_reset: done");
   endtask

   task automatic test_glitch();
      logic [4:0] got;
      KeyStart = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         step();
         if (k == 2) KeyStart = 1'b0;
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== {S_IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL glitch k=%0d got=%b exp=%b", k, got, {S_IDLE, 3'b000});
         end
      end
      $display("test_glitch: done");
   endtask

   task automatic test_start();
      logic [4:0] got, exp;
      logic [1:0] es;
      logic       een;
      int         pulses = 0;
      KeyStart = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         step();
         es  = (k >= 7) ? S_RUN : S_IDLE;
         een = (k >= 11) && ((k - 7) % 4 == 0);
         exp = {es, een, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL start k=%0d got=%b exp=%b", k, got, exp);
         end
         if (En === 1'b1) pulses++;
         if (k == 10) KeyStart = 1'b0;
      end
      n_checks++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL start_pulse_count got=%0d exp=3", pulses);
      end
      $display("test_start: done");
   endtask

   // Entered right after an En edge, so the divider is 0; the press lands
   // when it holds 2.
   task automatic test_pause_resume();
      logic [4:0] got, exp;
      logic [1:0] es;
      logic       een;
      KeyStart = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         es  = (k >= 7) ? S_PAUSE : S_RUN;
         een = (k == 4);
         exp = {es, een, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL pause k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) KeyStart = 1'b0;
      end
      KeyStart = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         es  = (k >= 7) ? S_RUN : S_PAUSE;
         een = (k == 9) || (k == 13);
         exp = {es, een, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL resume k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) KeyStart = 1'b0;
      end
      $display("test_pause_resume: done");
   endtask

   // Divider is 1 on entry; a tick coincides with the clearing edge.
   task automatic test_clear_running();
      logic [4:0] got, exp;
      logic [1:0] es;
      logic       een;
      KeyClr = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         es  = (k >= 7) ? S_IDLE : S_RUN;
         een = (k == 3) || (k == 7);
         exp = {es, een, (k == 7), es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL clear k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) KeyClr = 1'b0;
      end
      $display("test_clear_running: done");
   endtask

   task automatic test_simultaneous();
      logic [4:0] got, exp;
      logic [1:0] es;
      logic       een;
      // IDLE -> RUN: first tick 4 cycles in shows the divider was cleared
      KeyStart = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         es  = (k >= 7) ? S_RUN : S_IDLE;
         een = (k == 11);
         exp = {es, een, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL simul_run k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) KeyStart = 1'b0;
      end
      // RUN -> PAUSE
      KeyStart = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         es  = (k >= 7) ? S_PAUSE : S_RUN;
         een = (k == 1) || (k == 5);
         exp = {es, een, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL simul_pause k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) KeyStart = 1'b0;
      end
      // Both keys together from PAUSE: clear wins
      KeyStart = 1'b1;
      KeyClr   = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         es  = (k >= 7) ? S_IDLE : S_PAUSE;
         exp = {es, 1'b0, (k == 7), 1'b0};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL simul_both k=%0d got=%b exp=%b", k, got, exp);
         end
         if (k == 10) begin
            KeyStart = 1'b0;
            KeyClr   = 1'b0;
         end
      end
      $display("test_simultaneous: done");
   endtask

   task automatic test_reset_midrun();
      logic [4:0] got, exp;
      logic [1:0] es;
      KeyStart = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         es  = (k >= 7) ? S_RUN : S_IDLE;
         exp = {es, 1'b0, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL midrun_start k=%0d got=%b exp=%b", k, got, exp);
         end
      end
      R = 1'b1;
      step();
      R = 1'b0;
      got = {State, En, CntR, Running};
      n_checks++;
      if (got !== {S_IDLE, 3'b000}) begin
         n_fail++;
         $display("FAIL midrun_reset got=%b exp=%b", got, {S_IDLE, 3'b000});
      end
      // Key still held: re-accepted once stable after reset release
      for (int k = 1; k <= 9; k++) begin
         step();
         es  = (k >= 7) ? S_RUN : S_IDLE;
         exp = {es, 1'b0, 1'b0, es == S_RUN};
         got = {State, En, CntR, Running};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL midrun_rerun k=%0d got=%b exp=%b", k, got, exp);
         end
      end
      KeyStart = 1'b0;
      $display("test_reset_midrun: done");
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_start();
      test_pause_resume();
      test_clear_running();
      test_simultaneous();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control stage that sits directly upstream of the decade-counter chain and drives each digit's `En` and `R` inputs. It debounces two push-buttons, Start/Stop and Clear, and runs an IDLE/RUN/PAUSE state machine. It also divides the board clock into a one-cycle count-enable tick that is only emitted while running. Its outputs wire straight to the least-significant decade counter (`En`) and to all counters' clear (`CntR`).

## Interface
- `TICK_DIV`, 500000: clock cycles per `En` tick (100 Hz from 50 MHz). Must be ≥ 2.
- `DEB_CYCLES`, 1000000: consecutive stable synchronized samples required to accept a key level change (20 ms). Must be ≥ 2.
- `Clk`, in, 1: single system clock, all logic on rising edge.
- `R`, in, 1: synchronous active-high reset.
- `KeyStart`, in, 1: raw Start/Stop button, asynchronous, active-high when pressed.
- `KeyClr`, in, 1: raw Clear button, asynchronous, active-high when pressed.
- `En`, out, 1: one-cycle count-enable pulse to the decade counter. Registered.
- `CntR`, out, 1: one-cycle clear pulse to all counters. Registered.
- `Running`, out, 1: high while State = RUN. Registered.
- `State`, out, 2: current FSM state, encoded as IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.

## Operation
- **Synchronizer.** Each key passes through a 2-FF synchronizer.
- **Debounce (per key).** The debouncer holds a level `db` and a counter `dc`.
  - If the synchronized sample equals `db`, then `dc` ← 0.
  - Otherwise `dc` ← `dc`+1. When `dc` = DEB_CYCLES−1, then `db` ← sample and `dc` ← 0.
  - A glitch shorter than DEB_CYCLES cycles never changes `db`.
- **Press event.** A registered one-cycle pulse is generated on each rising edge of `db`. Releases generate no event.
- **FSM transitions.**
  - IDLE + start press → RUN.
  - RUN + start press → PAUSE.
  - PAUSE + start press → RUN.
  - Any state + clear press → IDLE, with `CntR` high for exactly one cycle.
  - Clear and start pressed in the same cycle: clear wins and the start press is discarded.
  - State 2'b11 is illegal and recovers to IDLE on the next edge, with no `CntR`.
- **Divider `div`** (width = clog2(TICK_DIV)).
  - Counts 0..TICK_DIV−1 and wraps only while State = RUN.
  - Holds its value in PAUSE, so the partial tick is preserved.
  - Forced to 0 in IDLE and on reset.
- **En.** `En` ← (State = RUN && `div` = TICK_DIV−1). Pulses are therefore spaced exactly TICK_DIV cycles apart while running, and no `En` is ever issued outside RUN.
- **Reset.** While `R` is high:
  - `State` = IDLE; `En`, `CntR` and `Running` = 0.
  - `div` and both debounce counters = 0.
  - Debounced levels = 0; synchronizer flops = 0.
  - A key held through reset is accepted as a press once it has been stable DEB_CYCLES cycles after release of `R`.

## Timing
- **Key-to-state latency.** A raw key edge that stays stable reaches `State`/`Running` in exactly DEB_CYCLES + 4 cycles: 2 synchronizer, DEB_CYCLES debounce, 1 event register, 1 state register.
- **Clear latency.** `CntR` asserts in the same cycle that `State` becomes IDLE.
- **First tick after IDLE → RUN.** `En` first pulses TICK_DIV cycles after the first cycle with State = RUN.
- **PAUSE → RUN resume.** The next `En` arrives after the remaining (TICK_DIV − `div`) cycles.
- **Entering PAUSE on a tick.** If PAUSE is entered on the same edge where `div` = TICK_DIV−1, `En` still fires for that final RUN cycle. The divider freezes at TICK_DIV−1 and the tick is not repeated on resume; `div` wraps to 0 on the first resumed RUN cycle.
- **Mid-operation reset.** Takes effect on the next edge. Any pending event or partial debounce is lost.

## Structure
- `stopwatch_pkg` contains the state typedef/localparams (IDLE, RUN, PAUSE) and the default TICK_DIV and DEB_CYCLES values.
- Sub-module `key_debounce` (parameter DEB_CYCLES; ports Clk, R, Key, Level, Press) contains the synchronizer, debounce counter and press-edge register. It is instantiated twice.
- The top level holds the FSM, divider and output registers.

## Test plan
All scenarios use TICK_DIV=4 and DEB_CYCLES=3.
- **Start.** Hold KeyStart 10 cycles after reset → State=RUN on cycle 7 after the raw rise; then `En` pulses every 4 cycles; 3 pulses after 12 more cycles.
- **Glitch rejection.** KeyStart high 2 cycles, then low → State stays IDLE and `En` stays 0 indefinitely.
- **Pause/resume.** RUN with `div`=2, press start → PAUSE and `div` frozen at 2. Press start again → first `En` 2 cycles after re-entering RUN.
- **Clear while running.** Press KeyClr while RUN → `CntR` high one cycle together with State=IDLE; `div`=0; no `En` afterwards.
- **Simultaneous press.** Press KeyStart and KeyClr in the same cycle while PAUSE → IDLE and `CntR`=1; no transition to RUN.
- **Reset mid-run.** Assert `R` for 1 cycle mid-RUN → next cycle State=IDLE, `En`=`CntR`=`Running`=0. With KeyStart still held, RUN re-entered 7 cycles after `R` deasserts.
